// File: rtl/universal_register_pkg.sv
// Shared types for the universal register: operation encoding and FSM states.
package universal_register_pkg;

  // Operation selector carried on the op port
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_ROR   = 3'd7
  } op_e;

  // Control FSM states; SHIFT is the only multi-cycle state
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the ops that run one bit per clock in SHIFT
  function automatic logic is_shift_op(input op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROR);
  endfunction

endpackage

// File: rtl/universal_register_step.sv
// One-bit shift/rotate step: purely combinational next value and shifted-out bit.
module universal_register_step
  import universal_register_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] q,
  input  op_e             op,
  input  logic            fill,
  output logic [SIZE-1:0] q_next,
  output logic            out_bit
);

  // Select the single-step transform for the latched shift op
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[SIZE-2:0], fill};
        out_bit = q[SIZE-1];
      end
      OP_SHR: begin
        q_next  = {fill, q[SIZE-1:1]};
        out_bit = q[0];
      end
      OP_ROR: begin
        q_next  = {q[0], q[SIZE-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Universal register: single-cycle load/clear/inc/dec plus multi-cycle
// shift/rotate sequenced by a two-state FSM, with a registered done pulse.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int              SIZE      = 8,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [SIZE-1:0]        D,
  input  logic [$clog2(SIZE):0]  amt,
  input  logic                   sin,
  output logic [SIZE-1:0]        Q,
  output logic                   busy,
  output logic                   done,
  output logic                   carry,
  output logic                   sout,
  output logic                   zero
);

  localparam int            CW     = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  state_e          state_reg, state_next;
  logic [SIZE-1:0] q_reg, q_next;
  logic [CW-1:0]   count_reg, count_next;
  op_e             op_lat_reg, op_lat_next;
  logic            sin_lat_reg, sin_lat_next;
  logic            done_reg, done_next;
  logic            carry_reg, carry_next;
  logic            sout_reg, sout_next;

  op_e             op_in;
  logic [CW-1:0]   amt_clamped;
  logic [SIZE-1:0] step_q;
  logic            step_out;

  assign op_in       = op_e'(op);
  // Counts beyond the register width saturate at one full pass
  assign amt_clamped = (amt > SIZE_C) ? SIZE_C : amt;

  universal_register_step #(
    .SIZE (SIZE)
  ) u_step (
    .q       (q_reg),
    .op      (op_lat_reg),
    .fill    (sin_lat_reg),
    .q_next  (step_q),
    .out_bit (step_out)
  );

  // FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and datapath decode; done defaults low so it pulses for one cycle
  always_comb begin
    state_next   = state_reg;
    q_next       = q_reg;
    count_next   = count_reg;
    op_lat_next  = op_lat_reg;
    sin_lat_next = sin_lat_reg;
    done_next    = 1'b0;
    carry_next   = carry_reg;
    sout_next    = sout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(op_in)) begin
            if (amt_clamped == '0) begin
              // Zero-length shift completes immediately, sout untouched
              done_next  = 1'b1;
              carry_next = 1'b0;
            end else begin
              op_lat_next  = op_in;
              sin_lat_next = sin;
              count_next   = amt_clamped;
              state_next   = ST_SHIFT;
            end
          end else begin
            done_next  = 1'b1;
            carry_next = 1'b0;
            case (op_in)
              OP_LOAD:  q_next = D;
              OP_CLEAR: q_next = '0;
              OP_INC: begin
                q_next     = q_reg + 1'b1;
                carry_next = &q_reg;
              end
              OP_DEC: begin
                q_next     = q_reg - 1'b1;
                carry_next = ~|q_reg;
              end
              default:  q_next = q_reg;
            endcase
          end
        end
      end
      ST_SHIFT: begin
        q_next     = step_q;
        sout_next  = step_out;
        count_next = count_reg - 1'b1;
        if (count_reg == CW'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          carry_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q_reg       <= RESET_VAL;
      count_reg   <= '0;
      op_lat_reg  <= OP_HOLD;
      sin_lat_reg <= 1'b0;
      done_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      sout_reg    <= 1'b0;
    end else begin
      q_reg       <= q_next;
      count_reg   <= count_next;
      op_lat_reg  <= op_lat_next;
      sin_lat_reg <= sin_lat_next;
      done_reg    <= done_next;
      carry_reg   <= carry_next;
      sout_reg    <= sout_next;
    end
  end

  assign Q     = q_reg;
  assign busy  = (state_reg == ST_SHIFT);
  assign done  = done_reg;
  assign carry = carry_reg;
  assign sout  = sout_reg;
  assign zero  = (q_reg == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register (SIZE=8, RESET_VAL=0).
module tb_universal_register;

  logic       Clock;
  logic       Reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] D;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] Q;
  logic       busy, done, carry, sout, zero;

  int n_assert = 0;
  int n_fail   = 0;

  universal_register #(
    .SIZE      (8),
    .RESET_VAL (8'h00)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .op    (op),
    .D     (D),
    .amt   (amt),
    .sin   (sin),
    .Q     (Q),
    .busy  (busy),
    .done  (done),
    .carry (carry),
    .sout  (sout),
    .zero  (zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present one start request for a single sampling edge
  task automatic issue(input logic [2:0] o, input logic [7:0] d, input logic [3:0] a, input logic s);
    start = 1'b1; op = o; D = d; amt = a; sin = s;
    tick();
    start = 1'b0;
    $display("op=%0d D=%02h amt=%0d sin=%0b -> Q=%02h busy=%0b done=%0b carry=%0b sout=%0b zero=%0b",
             o, d, a, s, Q, busy, done, carry, sout, zero);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; op = 3'd0; D = 8'h00; amt = 4'd0; sin = 1'b0;
    tick(); tick();
    check("rst_q", Q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_carry", carry, 1'b0);
    check("rst_sout", sout, 1'b0);
    check("rst_zero", zero, 1'b1);
    Reset = 1'b1;

    // First edge after reset release accepts a LOAD
    issue(3'd1, 8'b00000110, 4'd0, 1'b0);
    check("load06_q", Q, 8'h06);
    check("load06_done", done, 1'b1);
    check("load06_busy", busy, 1'b0);
    check("load06_zero", zero, 1'b0);
    tick();
    check("load06_done_clr", done, 1'b0);

    // Back-to-back single-cycle ops: LOAD FF, INC, DEC, HOLD
    issue(3'd1, 8'hFF, 4'd0, 1'b0);
    check("loadff_q", Q, 8'hFF);
    issue(3'd3, 8'h00, 4'd0, 1'b0);
    check("inc_q", Q, 8'h00);
    check("inc_carry", carry, 1'b1);
    check("inc_zero", zero, 1'b1);
    check("inc_done_b2b", done, 1'b1);
    issue(3'd4, 8'h00, 4'd0, 1'b0);
    check("dec_q", Q, 8'hFF);
    check("dec_carry", carry, 1'b1);
    issue(3'd0, 8'h12, 4'd0, 1'b0);
    check("hold_q", Q, 8'hFF);
    check("hold_carry", carry, 1'b0);
    check("hold_done", done, 1'b1);
    issue(3'd4, 8'h00, 4'd0, 1'b0);
    check("dec_nowrap_q", Q, 8'hFE);
    check("dec_nowrap_carry", carry, 1'b0);
    issue(3'd2, 8'h55, 4'd0, 1'b0);
    check("clear_q", Q, 8'h00);
    tick();
    check("clear_done_clr", done, 1'b0);

    // SHL by 3 with sin=1; start/op/D toggled while busy must be ignored
    issue(3'd1, 8'b11001011, 4'd0, 1'b0);
    issue(3'd5, 8'h00, 4'd3, 1'b1);
    check("shl_accept_busy", busy, 1'b1);
    check("shl_accept_q", Q, 8'hCB);
    check("shl_accept_done", done, 1'b0);
    start = 1'b1; op = 3'd1; D = 8'h00; amt = 4'd1; sin = 1'b0;
    tick();
    check("shl_s1_q", Q, 8'h97);
    check("shl_s1_sout", sout, 1'b1);
    check("shl_s1_busy", busy, 1'b1);
    start = 1'b0;
    tick();
    check("shl_s2_q", Q, 8'h2F);
    check("shl_s2_busy", busy, 1'b1);
    check("shl_s2_done", done, 1'b0);
    tick();
    check("shl_s3_q", Q, 8'b01011111);
    check("shl_s3_sout", sout, 1'b0);
    check("shl_s3_busy", busy, 1'b0);
    check("shl_s3_done", done, 1'b1);
    tick();
    check("shl_done_clr", done, 1'b0);
    check("shl_hold_q", Q, 8'h5F);

    // ROR with amt=9 clamps to 8 steps and comes back to the start value
    issue(3'd1, 8'h81, 4'd0, 1'b0);
    issue(3'd7, 8'h00, 4'd9, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ror_busy%0d", i), busy, 1'b1);
      tick();
    end
    check("ror_end_busy", busy, 1'b0);
    check("ror_end_done", done, 1'b1);
    check("ror_end_q", Q, 8'h81);
    check("ror_end_sout", sout, 1'b1);

    // SHR with amt=0 is a no-op that still completes on the next cycle
    issue(3'd6, 8'h00, 4'd0, 1'b0);
    check("shr0_done", done, 1'b1);
    check("shr0_busy", busy, 1'b0);
    check("shr0_q", Q, 8'h81);
    check("shr0_sout", sout, 1'b1);
    tick();

    // Reset mid-way through SHR by 5 aborts with no done pulse
    issue(3'd1, 8'hA5, 4'd0, 1'b0);
    issue(3'd6, 8'h00, 4'd5, 1'b0);
    tick();
    check("shr_s1_q", Q, 8'h52);
    check("shr_s1_sout", sout, 1'b1);
    tick();
    #2;
    Reset = 1'b0;
    #1;
    check("abort_q", Q, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sout", sout, 1'b0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort_nodone%0d", i), done, 1'b0);
    end

    // Start accepted again right after reset recovery
    issue(3'd1, 8'h3C, 4'd0, 1'b0);
    check("post_rst_q", Q, 8'h3C);
    check("post_rst_done", done, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 The module SHALL have parameter SIZE, default 8, giving the register width in bits (SIZE >= 2).
REQ-002 The module SHALL have parameter RESET_VAL, default 0, giving the value Q takes on reset.
REQ-003 Port Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port start  input  1  SHALL request execution of op; it is sampled only in IDLE.
REQ-006 Port op  input  3  SHALL select the operation: 0 HOLD, 1 LOAD, 2 CLEAR, 3 INC, 4 DEC, 5 SHL, 6 SHR, 7 ROR.
REQ-007 Port D  input  SIZE  SHALL be the parallel load data.
REQ-008 Port amt  input  $clog2(SIZE)+1  SHALL be the shift/rotate count for ops 5-7.
REQ-009 Port sin  input  1  SHALL be the serial fill bit for SHL and SHR.
REQ-010 Port Q  output  SIZE  SHALL be the registered contents.
REQ-011 Ports busy, done, carry, sout  output  1 each: multi-cycle op in progress; one-cycle completion pulse; INC/DEC wrap flag; last bit shifted out.
REQ-012 Port zero  output  1  SHALL be combinational (Q == 0).

Function
REQ-013 The FSM SHALL have states IDLE and SHIFT; busy SHALL be 1 exactly when the state is SHIFT.
REQ-014 In IDLE with start=1, ops 0-4 SHALL complete at that edge: HOLD leaves Q unchanged; LOAD sets Q=D; CLEAR sets Q=0; INC sets Q=Q+1; DEC sets Q=Q-1 (mod 2^SIZE).
REQ-015 On INC, carry SHALL be set to 1 iff Q was all ones; on DEC, carry SHALL be set to 1 iff Q was 0; every other completed op SHALL clear carry.
REQ-016 For ops 5-7 with amt=0, the op SHALL complete at the sampling edge as a no-op, and sout SHALL be unchanged.
REQ-017 For ops 5-7 with amt=k>=1 (k clamped to SIZE when larger), the sampling edge SHALL latch op, sin and k, enter SHIFT, and leave Q unchanged.
REQ-018 In SHIFT, each of the next k edges SHALL perform one step; after the k-th step the FSM SHALL return to IDLE.
REQ-019 An SHL step SHALL set Q={Q[SIZE-2:0],sin_latched} and sout=old Q[SIZE-1].
REQ-020 An SHR step SHALL set Q={sin_latched,Q[SIZE-1:1]} and sout=old Q[0].
REQ-021 A ROR step SHALL set Q={Q[0],Q[SIZE-1:1]} and sout=old Q[0].
REQ-022 done SHALL be registered and high for exactly the one cycle following the completing edge; every accepted start SHALL yield exactly one done pulse.
REQ-023 start, op, D, amt and sin SHALL be ignored while busy=1; the shift SHALL use only the latched values.
REQ-024 A start sampled in IDLE at the same edge that a done pulse is asserted SHALL be accepted (back-to-back operation).

Reset
REQ-025 When Reset=0, the block SHALL immediately set Q=RESET_VAL, state=IDLE, busy=0, done=0, carry=0, sout=0, and shift count=0, regardless of the clock.
REQ-026 A reset during SHIFT SHALL abort the operation without producing a done pulse.
REQ-027 After Reset rises, the first rising edge SHALL be able to accept start.

Structure
REQ-028 The op encoding enum and the FSM state enum SHALL be defined in shared package universal_register_pkg.
REQ-029 The one-step shift/rotate datapath SHALL be sub-module universal_register_step (combinational: Q, op, fill bit -> next Q, out bit); everything else SHALL be inline.

Verification (SIZE=8, RESET_VAL=0)
REQ-030 Reset=0, then Reset=1, then LOAD with D=8'b00000110 -> Q=8'h06, done pulse 1 cycle after the edge, busy never 1, zero=0.
REQ-031 LOAD 8'hFF, then INC -> Q=8'h00, carry=1, zero=1; then DEC -> Q=8'hFF, carry=1; then HOLD -> Q=8'hFF, carry=0.
REQ-032 LOAD 8'b11001011, then SHL with amt=3 and sin=1 -> busy high for 3 cycles, Q=8'b01011111, sout=0, and start toggled during busy has no effect.
REQ-033 LOAD 8'h81, then ROR with amt=9 -> clamped to 8 steps, Q=8'h81 after 8 busy cycles, sout=1; SHR with amt=0 -> done next cycle, Q unchanged.
REQ-034 Assert Reset=0 mid-way through an SHR of amt=5 -> Q=0 and busy=0 asynchronously, and no done pulse is produced.
REQ-035 Issue start again in the cycle done is high -> the second op is accepted, and two done pulses occur across a continuous op stream.
